// File: rtl/reg_access_master.sv
// Byte-stream command master: decodes USB rx command/data bytes into register-file
// writes, and streams register-file reads back out on the tx byte path.
module reg_access_master #(
  parameter int ADDR_W = 4
) (
  input  logic              useClk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              reg_we,
  output logic              reg_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_ADDR, RD_CAP, RD_SEND} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        cnt;
  logic              rxHs, txHs;

  assign rxHs = rx_valid && rx_ready;
  assign txHs = tx_valid && tx_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge useClk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    rx_ready = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) nxt = rx_data[7] ? WR_DATA : RD_ADDR;
      end
      WR_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && cnt == 3'd0) nxt = IDLE;
      end
      RD_ADDR: nxt = RD_CAP;
      RD_CAP:  nxt = RD_SEND;
      RD_SEND: if (txHs) nxt = (cnt == 3'd0) ? IDLE : RD_ADDR;
      default: nxt = IDLE;
    endcase
  end

  // Strobes default low every cycle so they are single-cycle pulses per handshake.
  always_ff @(posedge useClk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      reg_we    <= 1'b0;
      reg_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      reg_we <= 1'b0;
      reg_oe <= 1'b0;
      case (state)
        IDLE: if (rxHs) begin
          ptr <= rx_data[ADDR_W-1:0];
          cnt <= rx_data[6:4];
        end
        WR_DATA: if (rxHs) begin
          reg_addr  <= ptr;
          reg_wdata <= rx_data;
          reg_we    <= 1'b1;
          reg_oe    <= 1'b1;
          ptr       <= ptr + 1'b1;
          if (cnt != 3'd0) cnt <= cnt - 1'b1;
        end
        RD_ADDR: reg_addr <= ptr;
        // reg_rdata is combinational from reg_addr set in RD_ADDR
        RD_CAP: begin
          tx_data  <= reg_rdata;
          tx_valid <= 1'b1;
        end
        RD_SEND: if (txHs) begin
          tx_valid <= 1'b0;
          ptr      <= ptr + 1'b1;
          if (cnt != 3'd0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
- Byte-stream command master that drives the 16 x 8 register file from the USB byte path.
- Decodes command bytes from the USB receive stream into register-file writes. Turns read commands into a byte stream on the USB transmit side.
- Supports bursts of 1-8 bytes with auto-incrementing, wrapping addresses.
- Sits between the USB FIFO interface and the register file. It is the initiator for the register file's write strobe / address / data port.

Parameters:
- ADDR_W, 4, register-file address width. The command byte carries the address in bits [ADDR_W-1:0]; only the value 4 is supported.

Ports:
- useClk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous active-high reset
- rx_valid  input  1  receive byte available
- rx_data  input  8  receive byte
- rx_ready  output  1  master accepts rx_data this cycle; transfer when rx_valid && rx_ready
- tx_valid  output  1  transmit byte available
- tx_data  output  8  transmit byte
- tx_ready  input  1  sink accepts tx_data; transfer when tx_valid && tx_ready
- reg_we  output  1  register-file write strobe (checkData side)
- reg_oe  output  1  register-file write enable qualifier; asserted together with reg_we
- reg_addr  output  ADDR_W  register-file address
- reg_wdata  output  8  register-file write data
- reg_rdata  input  8  register-file read data; combinational from reg_addr
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - reg_we=0, reg_oe=0, reg_addr=0, reg_wdata=0, tx_valid=0, tx_data=0, busy=0.
  - Internal address pointer ptr=0 and count cnt=0.
  - Reset mid-burst abandons the burst with no further strobe. The next accepted byte is treated as a command.
- Command byte format:
  - bit7 = 1 for write, 0 for read.
  - bits[6:4] = burst length - 1, giving 1..8 bytes.
  - bits[3:0] = start address.
- rx_ready is combinational: 1 in IDLE and WR_DATA, 0 in all read states.
- States: IDLE, WR_DATA, RD_ADDR, RD_CAP, RD_SEND.
- IDLE: on rx handshake, ptr <= rx_data[3:0] and cnt <= rx_data[6:4].
  - Next state is WR_DATA if bit7=1, else RD_ADDR.
- WR_DATA: on each rx handshake:
  - Registered outputs next cycle: reg_addr <= ptr, reg_wdata <= rx_data, reg_we <= 1, reg_oe <= 1.
  - ptr <= ptr+1, wrapping 15 -> 0.
  - If cnt==0, go to IDLE; else cnt <= cnt-1.
  - reg_we/reg_oe are single-cycle pulses, 0 in any cycle without a handshake in the previous cycle.
  - Back-to-back handshakes give consecutive strobe cycles with consecutive addresses.
- RD_ADDR: reg_addr <= ptr; go to RD_CAP.
- RD_CAP: tx_data <= reg_rdata, tx_valid <= 1; go to RD_SEND.
- RD_SEND: tx_valid and tx_data are held stable until tx_ready. On the handshake:
  - tx_valid <= 0 and ptr <= ptr+1 (wrapping).
  - If cnt==0, go to IDLE; else cnt <= cnt-1 and go to RD_ADDR.
  - Throughput is 1 byte per 3 cycles when tx_ready is held high.
- reg_we and reg_oe are never asserted in read states.
- The rx byte following the last write data byte is accepted in IDLE as a new command. There is no gap cycle requirement.
- Latency: write strobe appears 1 cycle after the data byte handshake. First tx_valid appears 3 cycles after the read-command handshake.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; busy=0; rx_ready=1.
- Single write: rx 0x83, then 0x5A -> one-cycle reg_we=reg_oe=1 with reg_addr=3, reg_wdata=0x5A; then IDLE, busy=0.
- Wrapping write burst: rx 0xBE (write, 4 bytes, addr 14), then 0x11, 0x22, 0x33, 0x44 back-to-back -> strobes at addresses 14, 15, 0, 1 with the matching data on consecutive cycles.
- Read burst with backpressure: model register file preloaded with mem[k]=0xA0+k; rx 0x2F (read, 3 bytes, addr 15); tx_ready toggles every other cycle -> tx bytes 0xAF, 0xA0, 0xA1 in order. tx_data is stable while tx_valid && !tx_ready; rx_ready=0 throughout the read.
- Reset mid-burst: rx 0xF0, two data bytes, then rst pulse, then 0x80, 0x77 -> only addresses 0 and 1 are written before reset. After reset, 0x80 is decoded as a command and addr 0 is written with 0x77.
- Max read: rx 0x70 with tx_ready=1 constant -> exactly 8 tx handshakes (addresses 0..7), each 3 cycles apart; busy falls the cycle after the 8th handshake.
